// File: rtl/or_reduce_pipe.sv
// Pipelined FANIN-ary OR reduction of NUM_IN lanes with valid tracking,
// sticky OR accumulator and saturating hit counter.
module or_reduce_pipe #(
    parameter int unsigned NUM_IN = 8,
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned FANIN  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    sticky_clr,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        Y,
    output logic                    any_hit,
    output logic [WIDTH-1:0]        sticky,
    output logic [CNT_W-1:0]        hit_cnt
);

    function automatic int unsigned tree_stages(input int unsigned n, input int unsigned f);
        int unsigned s;
        int unsigned span;
        s    = 0;
        span = 1;
        while (span < n) begin
            span = span * f;
            s    = s + 1;
        end
        return (s == 0) ? 1 : s;
    endfunction

    function automatic int unsigned level_nodes(input int unsigned lvl);
        int unsigned c;
        c = NUM_IN;
        for (int unsigned i = 0; i < lvl; i++) c = (c + FANIN - 1) / FANIN;
        return c;
    endfunction

    // Registers of all stages live in one flat array; stage lvl (1-based) starts here.
    function automatic int unsigned level_base(input int unsigned lvl);
        int unsigned b;
        b = 0;
        for (int unsigned i = 1; i < lvl; i++) b = b + level_nodes(i);
        return b;
    endfunction

    localparam int unsigned STAGES = tree_stages(NUM_IN, FANIN);
    localparam int unsigned NODES  = level_base(STAGES + 1);

    logic [WIDTH-1:0]  node [NODES];
    logic [STAGES-1:0] valid_q;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned N_SRC    = level_nodes(s);
        localparam int unsigned N_DST    = level_nodes(s + 1);
        localparam int unsigned SRC_BASE = level_base(s);
        localparam int unsigned DST_BASE = level_base(s + 1);

        for (genvar j = 0; j < N_DST; j++) begin : g_node
            localparam int unsigned FIRST = j * FANIN;
            localparam int unsigned CHUNK = (N_SRC - FIRST < FANIN) ? (N_SRC - FIRST) : FANIN;

            // Running OR over the chunk; the last chunk of a stage may be short.
            logic [WIDTH-1:0] acc [CHUNK+1];
            assign acc[0] = '0;

            for (genvar k = 0; k < CHUNK; k++) begin : g_term
                if (s == 0) begin : g_leaf
                    assign acc[k+1] = acc[k] | in_data[(FIRST+k)*WIDTH +: WIDTH];
                end else begin : g_inner
                    assign acc[k+1] = acc[k] | node[SRC_BASE + FIRST + k];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) node[DST_BASE + j] <= '0;
                else       node[DST_BASE + j] <= acc[CHUNK];
            end
        end
    end

    if (STAGES == 1) begin : g_valid_one
        always_ff @(posedge clk) begin
            if (reset) valid_q <= '0;
            else       valid_q <= in_valid;
        end
    end else begin : g_valid_many
        always_ff @(posedge clk) begin
            if (reset) valid_q <= '0;
            else       valid_q <= {valid_q[STAGES-2:0], in_valid};
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign Y         = node[NODES-1];
    assign any_hit   = out_valid & (|Y);

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky  <= '0;
            hit_cnt <= '0;
        end else begin
            sticky <= (sticky_clr ? '0 : sticky) | (out_valid ? Y : '0);
            if (sticky_clr)
                hit_cnt <= any_hit ? CNT_W'(1) : '0;
            else if (any_hit && (hit_cnt != '1))
                hit_cnt <= hit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_or_reduce_pipe.sv
// Bench for or_reduce_pipe: three configurations share one stimulus stream
// and are checked against a per-cycle history model of the reduction.
module tb_or_reduce_pipe;

    localparam int HN = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, sticky_clr;
    logic [31:0] din_a;
    logic [14:0] din_b;
    logic [0:0]  din_c;

    logic       ov_a, ov_b, ov_c, hit_a, hit_b, hit_c;
    logic [3:0] y_a, stk_a;
    logic [2:0] y_b, stk_b;
    logic [0:0] y_c, stk_c;
    logic [2:0] cnt_a;
    logic [15:0] cnt_b;
    logic [1:0] cnt_c;

    or_reduce_pipe #(.NUM_IN(8), .WIDTH(4), .FANIN(4), .CNT_W(3)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(din_a),
        .sticky_clr(sticky_clr), .out_valid(ov_a), .Y(y_a), .any_hit(hit_a),
        .sticky(stk_a), .hit_cnt(cnt_a)
    );

    or_reduce_pipe #(.NUM_IN(5), .WIDTH(3), .FANIN(2), .CNT_W(16)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(din_b),
        .sticky_clr(sticky_clr), .out_valid(ov_b), .Y(y_b), .any_hit(hit_b),
        .sticky(stk_b), .hit_cnt(cnt_b)
    );

    or_reduce_pipe #(.NUM_IN(1), .WIDTH(1), .FANIN(4), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(din_c),
        .sticky_clr(sticky_clr), .out_valid(ov_c), .Y(y_c), .any_hit(hit_c),
        .sticky(stk_c), .hit_cnt(cnt_c)
    );

    logic [31:0] g_y [3];
    logic [31:0] g_stk [3];
    logic [31:0] g_cnt [3];
    logic        g_ov [3];
    logic        g_hit [3];

    always_comb begin
        g_y[0] = 32'(y_a);    g_y[1] = 32'(y_b);    g_y[2] = 32'(y_c);
        g_stk[0] = 32'(stk_a); g_stk[1] = 32'(stk_b); g_stk[2] = 32'(stk_c);
        g_cnt[0] = 32'(cnt_a); g_cnt[1] = 32'(cnt_b); g_cnt[2] = 32'(cnt_c);
        g_ov[0] = ov_a;  g_ov[1] = ov_b;  g_ov[2] = ov_c;
        g_hit[0] = hit_a; g_hit[1] = hit_b; g_hit[2] = hit_c;
    end

    // Pipeline depth follows from ceil(log_FANIN(NUM_IN)), minimum 1.
    int unsigned stages [3] = '{2, 3, 1};
    int unsigned cmax   [3] = '{7, 65535, 3};

    bit          v_h [HN];
    bit          r_h [HN];
    logic [31:0] or_h [3][HN];
    logic [31:0] m_stk [3];
    logic [31:0] m_cnt [3];
    logic [31:0] e_y [3];
    bit          e_ov [3];
    bit          e_rst;
    int unsigned edge_n;
    int          n_total, n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got=%0h expected=%0h", tag, edge_n, got, exp);
        end
    endtask

    // Advance the reference by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        logic [31:0] ors [3];
        logic [31:0] ta;
        logic [14:0] tb;
        bit          inc;
        int unsigned w;
        ors[0] = '0; ta = din_a;
        for (int k = 0; k < 8; k++) begin ors[0] |= 32'(ta[3:0]); ta = ta >> 4; end
        ors[1] = '0; tb = din_b;
        for (int k = 0; k < 5; k++) begin ors[1] |= 32'(tb[2:0]); tb = tb >> 3; end
        ors[2] = 32'(din_c);
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_stk[i] = '0;
                m_cnt[i] = '0;
            end else begin
                inc = e_ov[i] && (e_y[i] != 0);
                m_stk[i] = (sticky_clr ? 32'd0 : m_stk[i]) | (e_ov[i] ? e_y[i] : 32'd0);
                if (sticky_clr) m_cnt[i] = inc ? 32'd1 : 32'd0;
                else if (inc && m_cnt[i] < cmax[i]) m_cnt[i] = m_cnt[i] + 1;
            end
        end
        v_h[edge_n] = in_valid && !reset;
        r_h[edge_n] = reset;
        for (int i = 0; i < 3; i++) or_h[i][edge_n] = ors[i];
        for (int i = 0; i < 3; i++) begin
            e_ov[i] = 1'b0;
            e_y[i]  = '0;
            if (edge_n + 1 >= stages[i]) begin
                w = edge_n + 1 - stages[i];
                e_ov[i] = v_h[w];
                for (int unsigned j = w; j <= edge_n; j++) if (r_h[j]) e_ov[i] = 1'b0;
                e_y[i] = or_h[i][w];
            end
        end
        e_rst = reset;
        edge_n++;
    endtask

    task automatic check_outputs();
        string t;
        for (int i = 0; i < 3; i++) begin
            t = $sformatf("dut%0d", i);
            check({t, ".out_valid"}, 32'(g_ov[i]), 32'(e_ov[i]));
            if (e_ov[i])     check({t, ".Y"}, g_y[i], e_y[i]);
            else if (e_rst)  check({t, ".Y_reset"}, g_y[i], 32'd0);
            check({t, ".any_hit"}, 32'(g_hit[i]), 32'(e_ov[i] && (e_y[i] != 0)));
            check({t, ".sticky"}, g_stk[i], m_stk[i]);
            check({t, ".hit_cnt"}, g_cnt[i], m_cnt[i]);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] a, input logic [14:0] b,
                        input logic c, input logic clr, input logic rst);
        in_valid = v; din_a = a; din_b = b; din_c = c; sticky_clr = clr; reset = rst;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 'x, 'x, 1'bx, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] sparse32();
        if ($urandom_range(0, 2) == 0) return '0;
        return $urandom & $urandom & $urandom;
    endfunction

    initial begin
        logic v;
        n_total = 0; n_bad = 0; edge_n = 0; e_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e_ov[i] = 1'b0; e_y[i] = '0; m_stk[i] = '0; m_cnt[i] = '0;
        end

        repeat (3) step(1'b0, 'x, 'x, 1'bx, 1'b0, 1'b1);
        repeat (4) idle();

        // single word: lane3=4, lane6=1 on the 8x4 instance
        step(1'b1, 32'h0100_4000, 15'h100, 1'b1, 1'b0, 1'b0);
        repeat (4) idle();

        // back-to-back ORs 0x0, 0x8, 0x0, 0x3
        step(1'b1, 32'h0000_0000, 15'h000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0008, 15'h004, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0000, 15'h000, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h2000_0010, 15'h041, 1'b1, 1'b0, 1'b0);
        repeat (4) idle();

        // invalid words with all-ones data
        repeat (5) step(1'b0, '1, '1, 1'b1, 1'b0, 1'b0);

        // clear lands on the same edge that takes in a valid Y=4
        step(1'b1, 32'h0000_0400, 15'h004, 1'b1, 1'b0, 1'b0);
        idle();
        step(1'b0, 'x, 'x, 1'bx, 1'b1, 1'b0);
        repeat (4) idle();

        // counter saturation
        repeat (9) step(1'b1, 32'h1000_0000, 15'h001, 1'b1, 1'b0, 1'b0);
        repeat (4) idle();

        // reset while a word is in flight
        step(1'b1, 32'h0000_000F, 15'h007, 1'b1, 1'b0, 1'b0);
        idle();
        step(1'b0, 'x, 'x, 1'bx, 1'b0, 1'b1);
        repeat (6) idle();

        repeat (400) begin
            v = ($urandom_range(0, 3) != 0);
            if (v)
                step(1'b1, sparse32(), 15'(sparse32()), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
            else
                step(1'b0, 'x, 'x, 1'bx,
                     ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
        end
        repeat (5) idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
